// File: rtl/ctrl_unit_seq_pkg.sv
// Shared types and constants for the sequenced control unit: opcodes, funct codes,
// the ID/EX control bundle layout and FSM states.
package ctrl_unit_seq_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FN_W   = 4;
  localparam int unsigned CTRL_W = 11;

  localparam logic [OP_W-1:0] OP_TYPEA = 4'b0000;
  localparam logic [OP_W-1:0] OP_BLT   = 4'b0100;
  localparam logic [OP_W-1:0] OP_BGT   = 4'b0101;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OP_W-1:0] OP_STALL = 4'b0111;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_JMP   = 4'b1011;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1100;
  localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

  localparam logic [FN_W-1:0] FN_FPM = 4'b0010;
  localparam logic [FN_W-1:0] FN_MUL = 4'b0100;
  localparam logic [FN_W-1:0] FN_DIV = 4'b0101;

  // MSB first: {RegDst,ALUOp1,ALUOp0,ALUSrc,Branch,MemRead,MemWrite,Jump,RegWrite,MemtoReg,FPC}
  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       reg_write;
    logic       mem_to_reg;
    logic       fpc;
  } ex_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_unit_seq_if.sv
// Decode-stage bus between the pipeline (master) and the control unit (slave).
interface ctrl_unit_seq_if;
  import ctrl_unit_seq_pkg::*;

  logic              instr_valid;
  logic [OP_W-1:0]   opcode;
  logic [FN_W-1:0]   funct;
  logic              flush;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_valid;
  logic              pc_write;
  logic              ifid_write;
  logic              busy;
  logic              halted;

  modport master (
    output instr_valid, opcode, funct, flush,
    input  ex_ctrl, ex_valid, pc_write, ifid_write, busy, halted
  );

  modport slave (
    input  instr_valid, opcode, funct, flush,
    output ex_ctrl, ex_valid, pc_write, ifid_write, busy, halted
  );
endinterface

// File: rtl/ctrl_unit_seq_decode.sv
// Combinational {opcode,funct} decoder: control bundle plus sequencing hints.
module ctrl_unit_seq_decode
  import ctrl_unit_seq_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned FPM_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic [OP_W-1:0]  opcode_i,
  input  logic [FN_W-1:0]  funct_i,
  output ex_ctrl_t         ctrl_o,
  output logic             is_multi_o,
  output logic [CNT_W-1:0] lat_o,
  output logic             is_stall_o,
  output logic             is_halt_o
);

  always_comb begin
    ctrl_o     = '0;
    is_multi_o = 1'b0;
    lat_o      = '0;
    is_stall_o = 1'b0;
    is_halt_o  = 1'b0;
    unique case (opcode_i)
      OP_TYPEA: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = 2'b10;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.fpc       = (funct_i == FN_FPM);
        case (funct_i)
          FN_MUL:  begin is_multi_o = 1'b1; lat_o = CNT_W'(MUL_LAT); end
          FN_DIV:  begin is_multi_o = 1'b1; lat_o = CNT_W'(DIV_LAT); end
          FN_FPM:  begin is_multi_o = 1'b1; lat_o = CNT_W'(FPM_LAT); end
          default: ;
        endcase
      end
      OP_LOAD: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BLT, OP_BGT, OP_BEQ: begin
        ctrl_o.alu_op = 2'b01;
        ctrl_o.branch = 1'b1;
      end
      OP_JMP:   ctrl_o.jump = 1'b1;
      OP_STALL: is_stall_o = 1'b1;
      OP_HALT:  is_halt_o  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_seq.sv
// Sequenced control unit: registers decoded controls into ID/EX and inserts bubbles
// for multi-cycle ops, program stalls, halt and branch flushes.
module ctrl_unit_seq
  import ctrl_unit_seq_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_LAT   = 8,
  parameter int unsigned FPM_LAT   = 4,
  parameter int unsigned STALL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  ctrl_unit_seq_if.slave bus
);

  localparam int unsigned MAX_LAT = max_u(max_u(MUL_LAT, DIV_LAT), max_u(FPM_LAT, STALL_LAT));
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  ex_ctrl_t         ex_ctrl_q;
  logic             ex_valid_q;

  ex_ctrl_t         ctrl_c;
  logic             is_multi_c;
  logic [CNT_W-1:0] lat_c;
  logic             is_stall_c;
  logic             is_halt_c;
  logic             accept_c;
  logic             hold_c;

  ctrl_unit_seq_decode #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .FPM_LAT (FPM_LAT),
    .CNT_W   (CNT_W)
  ) u_decode (
    .opcode_i   (bus.opcode),
    .funct_i    (bus.funct),
    .ctrl_o     (ctrl_c),
    .is_multi_o (is_multi_c),
    .lat_o      (lat_c),
    .is_stall_o (is_stall_c),
    .is_halt_o  (is_halt_c)
  );

  assign accept_c = (state_q == ST_RUN) && bus.instr_valid && !bus.flush;
  // Freeze fetch in the same cycle an op that will occupy the stage is decoded
  assign hold_c   = accept_c && ((is_multi_c && (lat_c > CNT_W'(1)))
                              || (is_stall_c && (STALL_LAT > 1))
                              || is_halt_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (accept_c) begin
            ex_ctrl_q  <= ctrl_c;
            ex_valid_q <= !(is_stall_c || is_halt_c);
            if (is_multi_c) begin
              cnt_q <= lat_c - CNT_W'(1);
              if (lat_c > CNT_W'(1)) state_q <= ST_WAIT;
            end else if (is_stall_c) begin
              cnt_q <= CNT_W'(STALL_LAT - 1);
              if (STALL_LAT > 1) state_q <= ST_WAIT;
            end else if (is_halt_c) begin
              state_q <= ST_HALT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_RUN;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.pc_write   = (state_q == ST_RUN) && !hold_c;
  assign bus.ifid_write = (state_q == ST_RUN) && !hold_c;
  assign bus.busy       = (state_q == ST_WAIT);
  assign bus.halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Directed bench for ctrl_unit_seq: a default-latency instance and one with
// MUL_LAT=1/STALL_LAT=1, both driven with the same decode stream.
module tb_ctrl_unit_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ctrl_unit_seq_if bus ();
  ctrl_unit_seq_if bus_s ();

  ctrl_unit_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_unit_seq #(
    .MUL_LAT   (1),
    .STALL_LAT (1)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] fn, input logic fl);
    bus.instr_valid   = v;
    bus.opcode        = op;
    bus.funct         = fn;
    bus.flush         = fl;
    bus_s.instr_valid = v;
    bus_s.opcode      = op;
    bus_s.funct       = fn;
    bus_s.flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("rst_ex_ctrl",  32'(bus.ex_ctrl),  32'd0);
    check_eq("rst_pc_write", 32'(bus.pc_write), 32'd1);
    check_eq("rst_busy",     32'(bus.busy),     32'd0);
    check_eq("rst_halted",   32'(bus.halted),   32'd0);

    // Load
    drive(1'b1, 4'b1000, 4'h0, 1'b0);
    #1;
    check_eq("load_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    idle();
    check_eq("load_ctrl",  32'(bus.ex_ctrl),  32'h0A6);
    check_eq("load_valid", 32'(bus.ex_valid), 32'd1);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("async_rst_ctrl",  32'(bus.ex_ctrl),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_pc_write", 32'(bus.pc_write), 32'd1);

    // Type A add
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    tick();
    idle();
    check_eq("add_ctrl",  32'(bus.ex_ctrl),  32'h604);
    check_eq("add_valid", 32'(bus.ex_valid), 32'd1);

    // MUL: default stalls, MUL_LAT=1 instance stays in RUN
    drive(1'b1, 4'b0000, 4'b0100, 1'b0);
    #1;
    check_eq("mul_pc_write",   32'(bus.pc_write),   32'd0);
    check_eq("mul_s_pc_write", 32'(bus_s.pc_write), 32'd1);
    tick();
    idle();
    check_eq("mul_s_valid", 32'(bus_s.ex_valid), 32'd1);
    check_eq("mul_s_busy",  32'(bus_s.busy),     32'd0);
    check_eq("mul_busy",    32'(bus.busy),       32'd1);
    tick();
    check_eq("mul_bubble", 32'(bus.ex_valid), 32'd0);
    tick();
    check_eq("mul_done_busy", 32'(bus.busy), 32'd0);

    // DIV: 1 valid cycle then 7 bubbles with busy
    drive(1'b1, 4'b0000, 4'b0101, 1'b0);
    #1;
    check_eq("div_ifid_write", 32'(bus.ifid_write), 32'd0);
    tick();
    idle();
    check_eq("div_ctrl",  32'(bus.ex_ctrl),  32'h604);
    check_eq("div_valid", 32'(bus.ex_valid), 32'd1);
    check_eq("div_busy0", 32'(bus.busy),     32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_eq($sformatf("div_bubble%0d", i), 32'(bus.ex_valid), 32'd0);
      check_eq($sformatf("div_busy%0d", i),   32'(bus.busy),     (i < 7) ? 32'd1 : 32'd0);
      check_eq($sformatf("div_pcw%0d", i),    32'(bus.pc_write), (i < 7) ? 32'd0 : 32'd1);
    end

    // BEQ with flush is squashed
    drive(1'b1, 4'b0110, 4'h0, 1'b1);
    #1;
    check_eq("beqf_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    check_eq("beqf_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("beqf_ctrl",  32'(bus.ex_ctrl),  32'd0);
    drive(1'b1, 4'b0110, 4'h0, 1'b0);
    tick();
    check_eq("beq_ctrl",  32'(bus.ex_ctrl),  32'h140);
    check_eq("beq_valid", 32'(bus.ex_valid), 32'd1);

    // FPM with flush never enters WAIT
    drive(1'b1, 4'b0000, 4'b0010, 1'b1);
    tick();
    check_eq("fpmf_busy",  32'(bus.busy),     32'd0);
    check_eq("fpmf_valid", 32'(bus.ex_valid), 32'd0);

    // Store and jump
    drive(1'b1, 4'b1100, 4'h0, 1'b0);
    tick();
    check_eq("store_ctrl", 32'(bus.ex_ctrl), 32'h090);
    drive(1'b1, 4'b1011, 4'h0, 1'b0);
    tick();
    idle();
    check_eq("jmp_ctrl", 32'(bus.ex_ctrl), 32'h008);

    // FPM without flush: FPC set, 3 busy cycles
    drive(1'b1, 4'b0000, 4'b0010, 1'b0);
    tick();
    idle();
    check_eq("fpm_ctrl", 32'(bus.ex_ctrl), 32'h605);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq($sformatf("fpm_busy%0d", i), 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
    end

    // Stall: STALL_LAT=2 waits one cycle, STALL_LAT=1 does not
    drive(1'b1, 4'b0111, 4'h0, 1'b0);
    #1;
    check_eq("stall_pc_write",   32'(bus.pc_write),   32'd0);
    check_eq("stall_s_pc_write", 32'(bus_s.pc_write), 32'd1);
    tick();
    idle();
    check_eq("stall_valid",   32'(bus.ex_valid),   32'd0);
    check_eq("stall_s_valid", 32'(bus_s.ex_valid), 32'd0);
    check_eq("stall_busy",    32'(bus.busy),       32'd1);
    check_eq("stall_s_busy",  32'(bus_s.busy),     32'd0);
    tick();
    check_eq("stall_done_busy", 32'(bus.busy), 32'd0);

    // Undefined opcode passes as a valid no-op
    drive(1'b1, 4'b1110, 4'h0, 1'b0);
    tick();
    check_eq("undef_valid", 32'(bus_s.ex_valid), 32'd1);
    check_eq("undef_ctrl",  32'(bus_s.ex_ctrl),  32'd0);

    // Halt is sticky under random stimulus
    drive(1'b1, 4'b1111, 4'h0, 1'b0);
    #1;
    check_eq("halt_pc_write", 32'(bus.pc_write), 32'd0);
    tick();
    check_eq("halt_halted", 32'(bus.halted),   32'd1);
    check_eq("halt_valid",  32'(bus.ex_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      #1;
      check_eq($sformatf("halt_pcw%0d", i), 32'(bus.pc_write), 32'd0);
      tick();
      check_eq($sformatf("halt_hold%0d", i),  32'(bus.halted),   32'd1);
      check_eq($sformatf("halt_bub%0d", i),   32'(bus.ex_valid), 32'd0);
    end

    // Reset leaves HALT immediately
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("unhalt_halted",   32'(bus.halted),   32'd0);
    check_eq("unhalt_pc_write", 32'(bus.pc_write), 32'd1);
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b1000, 4'h0, 1'b0);
    tick();
    idle();
    check_eq("unhalt_load_valid", 32'(bus.ex_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
